// File: rtl/encrypt_block_sequencer.sv
// rtl/encrypt_block_sequencer.sv - byte-serial block sequencer around a combinational bytes_encrypter
// Collects a block, encrypts it in one cycle with a per-block offset, then streams it out.

module bytes_encrypter #(
    parameter int NUMBER_OF_BYTES = 512
) (
    input  logic [8*NUMBER_OF_BYTES-1:0] data_in_i,
    input  logic [7:0]                   key_i,
    input  logic [7:0]                   offset_i,
    output logic [8*NUMBER_OF_BYTES-1:0] data_out_o
);
    // Each byte is whitened with the key and a position-dependent offset stream.
    always_comb begin
        data_out_o = '0;
        for (int i = 0; i < NUMBER_OF_BYTES; i++) begin
            data_out_o[8*i +: 8] = data_in_i[8*i +: 8] ^ key_i ^ (offset_i + 8'(i));
        end
    end
endmodule

module encrypt_block_sequencer #(
    parameter int NUMBER_OF_BYTES = 512
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [15:0] num_blocks_i,
    input  logic [7:0]  key_i,
    input  logic [7:0]  offset_i,
    input  logic        abort_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] blocks_done_o
);
    localparam int CW = $clog2(NUMBER_OF_BYTES);
    localparam int BW = 8 * NUMBER_OF_BYTES;
    localparam logic [CW-1:0] LAST = CW'(NUMBER_OF_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ENCRYPT, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    key_q, key_d;
    logic [7:0]    offset_q, offset_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [15:0]   blocks_done_q, blocks_done_d;
    logic          done_q, done_d;
    logic [BW-1:0] block_q, outbuf_q, enc_data;
    logic          blk_we, obuf_we;

    bytes_encrypter #(.NUMBER_OF_BYTES(NUMBER_OF_BYTES)) u_enc (
        .data_in_i  (block_q),
        .key_i      (key_q),
        .offset_i   (offset_q),
        .data_out_o (enc_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_d         = key_q;
        offset_d      = offset_q;
        remaining_d   = remaining_q;
        blocks_done_d = blocks_done_q;
        done_d        = 1'b0;
        blk_we        = 1'b0;
        obuf_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i && num_blocks_i != 16'd0) begin
                    state_d       = S_FILL;
                    key_d         = key_i;
                    offset_d      = offset_i;
                    remaining_d   = num_blocks_i;
                    blocks_done_d = 16'd0;
                    cnt_d         = '0;
                end
            end
            S_FILL: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (in_valid_i) begin
                    blk_we = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_ENCRYPT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ENCRYPT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    obuf_we = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (out_ready_i) begin
                    if (cnt_q == LAST) begin
                        cnt_d         = '0;
                        blocks_done_d = (blocks_done_q == 16'hFFFF) ? blocks_done_q
                                                                    : blocks_done_q + 16'd1;
                        offset_d      = offset_q + 8'd1;
                        remaining_d   = remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            key_q         <= '0;
            offset_q      <= '0;
            remaining_q   <= '0;
            blocks_done_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_q         <= key_d;
            offset_q      <= offset_d;
            remaining_q   <= remaining_d;
            blocks_done_q <= blocks_done_d;
            done_q        <= done_d;
        end
    end

    // Wide buffers are only written on their enable, keeping them out of the FSM process.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            block_q  <= '0;
            outbuf_q <= '0;
        end else begin
            if (blk_we) block_q[{cnt_q, 3'b000} +: 8] <= in_data_i;
            if (obuf_we) outbuf_q <= enc_data;
        end
    end

    assign in_ready_o    = (state_q == S_FILL);
    assign out_valid_o   = (state_q == S_DRAIN);
    assign out_data_o    = outbuf_q[{cnt_q, 3'b000} +: 8];
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign blocks_done_o = blocks_done_q;

endmodule

// File: tb/tb_encrypt_block_sequencer.sv
// tb/tb_encrypt_block_sequencer.sv - directed scoreboard bench for encrypt_block_sequencer
module tb_encrypt_block_sequencer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid, out_ready;
    logic [15:0] num_blocks;
    logic [7:0]  key, offset, in_data;
    logic        in_ready, out_valid, busy, done;
    logic [7:0]  out_data;
    logic [15:0] blocks_done;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          done_base;
    logic [7:0]  sb_q[$];
    logic [7:0]  out_log[$];
    logic [7:0]  ref_log[$];

    encrypt_block_sequencer #(.NUMBER_OF_BYTES(N)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_blocks_i(num_blocks),
        .key_i(key), .offset_i(offset), .abort_i(abort),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy), .done_o(done), .blocks_done_o(blocks_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] nb, input logic [7:0] k, input logic [7:0] off,
                               input logic ab);
        start = 1'b1; num_blocks = nb; key = k; offset = off; abort = ab;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int idx, input int gap,
                             input logic [7:0] k, input logic [7:0] off);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d;
        sb_q.push_back(d ^ k ^ (off + 8'(idx)));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [7:0] k, input logic [7:0] off, input bit seq,
                              input int gap_max);
        for (int i = 0; i < N; i++) begin
            send_byte(seq ? 8'(i) : 8'($urandom), i,
                      gap_max > 0 ? int'($urandom_range(0, gap_max)) : 0, k, off);
        end
    endtask

    task automatic recv_block(input int stall_max);
        int          n, k;
        logic [7:0]  held;
        logic [31:0] exp;
        for (int i = 0; i < N; i++) begin
            n = 0;
            while (!out_valid && n < 50) begin @(negedge clk); n++; end
            chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
            k = stall_max > 0 ? int'($urandom_range(0, stall_max)) : 0;
            if (k > 0) begin
                out_ready = 1'b0;
                held = out_data;
                repeat (k) begin
                    @(negedge clk);
                    chk("hold_data", {24'd0, out_data}, {24'd0, held});
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                end
            end
            out_ready = 1'b1;
            exp = (sb_q.size() > 0) ? {24'd0, sb_q.pop_front()} : 32'hDEAD;
            chk("out_byte", {24'd0, out_data}, exp);
            out_log.push_back(out_data);
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num_blocks = 16'd0; key = 8'd0; offset = 8'd0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_blocks_done", {16'd0, blocks_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single block, no stalls, latency and done timing
        done_base = done_cnt;
        pulse_start(16'd1, 8'h5A, 8'h10, 1'b0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        send_block(8'h5A, 8'h10, 1'b1, 0);
        chk("t1_enc_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_enc_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("t1_latency_out_valid", {31'd0, out_valid}, 32'd1);
        recv_block(0);
        chk("t1_done_pulse", {31'd0, done}, 32'd1);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
        chk("t1_done_low", {31'd0, done}, 32'd0);
        chk("t1_blocks_done", {16'd0, blocks_done}, 32'd1);
        chk("t1_done_count", done_cnt - done_base, 32'd1);
        chk("t1_vector_byte0", {24'd0, out_log[0]}, 32'h4A);
        chk("t1_vector_byte3", {24'd0, out_log[3]}, 32'h4A);
        ref_log = out_log;
        out_log.delete();

        // three blocks with offset wrap, start pulse while busy
        done_base = done_cnt;
        pulse_start(16'd3, 8'h33, 8'hFE, 1'b0);
        pulse_start(16'd5, 8'h00, 8'h00, 1'b0);
        chk("t2_start_busy_ignored", {31'd0, busy}, 32'd1);
        for (int b = 0; b < 3; b++) begin
            send_block(8'h33, 8'hFE + 8'(b), 1'b0, 0);
            recv_block(0);
            if (b < 2) chk("t2_between_in_ready", {31'd0, in_ready}, 32'd1);
        end
        chk("t2_done", {31'd0, done}, 32'd1);
        @(negedge clk); #1;
        chk("t2_blocks_done", {16'd0, blocks_done}, 32'd3);
        chk("t2_done_count", done_cnt - done_base, 32'd1);
        out_log.delete();

        // random gaps and stalls against the no-stall reference
        pulse_start(16'd1, 8'h5A, 8'h10, 1'b0);
        send_block(8'h5A, 8'h10, 1'b1, 3);
        recv_block(4);
        for (int i = 0; i < N; i++) chk("t3_match_ref", {24'd0, out_log[i]}, {24'd0, ref_log[i]});
        @(negedge clk);
        chk("t3_blocks_done", {16'd0, blocks_done}, 32'd1);
        out_log.delete();

        // ignored starts
        pulse_start(16'd0, 8'h11, 8'h22, 1'b0);
        chk("t4_zero_blocks_busy", {31'd0, busy}, 32'd0);
        chk("t4_zero_blocks_in_ready", {31'd0, in_ready}, 32'd0);
        pulse_start(16'd2, 8'h11, 8'h22, 1'b1);
        chk("t4_abort_start_busy", {31'd0, busy}, 32'd0);
        chk("t4_blocks_done_kept", {16'd0, blocks_done}, 32'd1);

        // abort mid-fill of second block, then a clean session
        done_base = done_cnt;
        pulse_start(16'd2, 8'h77, 8'h20, 1'b0);
        send_block(8'h77, 8'h20, 1'b0, 0);
        recv_block(0);
        send_byte(8'hA1, 0, 0, 8'h77, 8'h21);
        send_byte(8'hA2, 1, 0, 8'h77, 8'h21);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_busy", {31'd0, busy}, 32'd0);
        chk("t5_abort_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_abort_blocks_done", {16'd0, blocks_done}, 32'd1);
        @(negedge clk); #1;
        chk("t5_abort_no_done", done_cnt - done_base, 32'd0);
        sb_q.delete();
        pulse_start(16'd1, 8'h81, 8'h40, 1'b0);
        chk("t5_restart_blocks_done", {16'd0, blocks_done}, 32'd0);
        send_block(8'h81, 8'h40, 1'b1, 0);
        recv_block(0);
        chk("t5_restart_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t5_restart_blocks_done_end", {16'd0, blocks_done}, 32'd1);
        out_log.delete();

        // reset asserted during drain
        pulse_start(16'd1, 8'h3C, 8'h05, 1'b0);
        send_block(8'h3C, 8'h05, 1'b0, 0);
        @(negedge clk);
        chk("t6_in_drain", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_out_data", {24'd0, out_data}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_blocks_done", {16'd0, blocks_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        chk("t6_idle_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_idle_done", {31'd0, done}, 32'd0);
        sb_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/encrypt_block_sequencer.md
# encrypt_block_sequencer

Byte-serial front end for `bytes_encrypter`. It collects `number_of_bytes` input bytes into a block register and applies them, with a latched key and per-block offset, to an internal `bytes_encrypter` instance. It captures the encrypted block and streams it out byte by byte. One `start` runs a session of N consecutive blocks; the offset advances by one per block, so a stream can be encrypted without software reprogramming between blocks.

## Interface
- `number_of_bytes`, 512: block size in bytes; passed unchanged to the internal `bytes_encrypter`; minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request to begin a session; honoured only in IDLE with `num_blocks` != 0.
- `num_blocks` in 16: blocks in the session, sampled on an accepted `start`.
- `key` in 8: encryption key, sampled on an accepted `start`.
- `offset` in 8: offset for block 0, sampled on an accepted `start`.
- `abort` in 1: synchronous session cancel.
- `in_data` in 8: input byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: the block accepts a byte this cycle.
- `out_data` out 8: encrypted byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: the sink accepts a byte this cycle.
- `busy` out 1: session active (state other than IDLE).
- `done` out 1: one-cycle pulse after the last byte of the last block drains.
- `blocks_done` out 16: completed blocks in the current or last session.

## Operation
- States: IDLE, FILL, ENCRYPT, DRAIN.
- **IDLE**
  - An accepted `start` latches `key_r`, `offset_r`, `remaining` = `num_blocks`.
  - It clears `blocks_done` and the byte counter, then moves to FILL.
  - `start` with `num_blocks` = 0 is ignored.
- **FILL**
  - `in_ready` = 1.
  - Each handshake (`in_valid` & `in_ready`) writes `in_data` to byte[cnt], at bits [8*cnt+7 : 8*cnt], then increments `cnt`.
  - The first byte received is byte 0.
  - Handshake at `cnt` = `number_of_bytes`-1: clear `cnt`, move to ENCRYPT.
- **ENCRYPT** (exactly 1 cycle)
  - The internal `bytes_encrypter` input is data = block register, key = `key_r`, offset = `offset_r`.
  - Its combinational `data_out` is registered into the output buffer. Move to DRAIN.
- **DRAIN**
  - `out_valid` = 1 and `out_data` = outbuf byte[cnt].
  - Each handshake (`out_valid` & `out_ready`) increments `cnt`.
  - Handshake on the last byte: `blocks_done` += 1, `offset_r` += 1 (mod 256, wraps 255→0), `remaining` -= 1, `cnt` cleared.
  - If `remaining` was 1: pulse `done` and go to IDLE. Otherwise go to FILL.
- `out_data` is held stable while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` is 0 outside FILL, and `out_valid` is 0 outside DRAIN. Input and output never overlap.
- **abort**
  - In any non-IDLE state: go to IDLE next cycle.
  - No `done` pulse. `blocks_done` keeps the count of completed blocks. A partial block is discarded.
  - `abort` has priority over handshakes in the same cycle.
  - In IDLE, `abort` is ignored. `abort` together with `start` in IDLE: `start` is ignored.
- `start` while busy: ignored. `key`/`offset` changes during a session have no effect.
- `blocks_done` saturates at 0xFFFF.

## Timing
- Reset values:
  - State = IDLE, all counters 0.
  - `in_ready` = 0, `out_valid` = 0, `out_data` = 0x00, `busy` = 0, `done` = 0, `blocks_done` = 0.
  - Block and output buffers = 0.
- `start` accepted at edge t: `busy` = 1 and `in_ready` = 1 from t+1.
- Last input byte accepted at edge t:
  - ENCRYPT during cycle t+1, `in_ready` = 0.
  - `out_valid` = 1 with byte 0 from t+2.
- Fixed latency from last input byte to first output byte: 2 cycles.
- Zero-stall throughput: 1 byte/cycle in each phase. One block takes `number_of_bytes` + 1 + `number_of_bytes` cycles.
- Last output byte of the final block accepted at edge t: `done` = 1 and `busy` = 0 during cycle t+1; `done` is 0 at t+2.
- Between blocks: `in_ready` = 1 the cycle after the last output handshake.
- All outputs are registered. No combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- `rst_n` low mid-session: immediate return to reset values. No `done` pulse.

## Test plan
- `number_of_bytes` = 4, `key` = 0x5A, `offset` = 0x10, `num_blocks` = 1, input 0x00,0x01,0x02,0x03 with no stalls:
  - Outputs equal a standalone `bytes_encrypter` (key 0x5A, offset 0x10) on the same bytes, in byte order.
  - First `out_valid` 2 cycles after the last input handshake.
  - `done` pulses once; `blocks_done` = 1.
- `num_blocks` = 3, `offset` = 0xFE: blocks use offsets 0xFE, 0xFF, 0x00; `blocks_done` = 3; exactly one `done`.
- Random `in_valid` gaps and `out_ready` stalls: `out_data` holds during stalls, no bytes are lost or duplicated, and the output matches the no-stall run bit for bit.
- `start` with `num_blocks` = 0, and `start` pulses while busy: no state change, the session is unaffected.
- `abort` after 2 input bytes of block 1 (of 2): IDLE next cycle, no `done`, `blocks_done` = 1. A new `start` then runs cleanly from byte 0.
- `rst_n` pulsed low during DRAIN: all outputs return to reset values immediately and stay there until the next `start`.
